// File: rtl/conc_stim_seq.sv
// Opcode-store stimulus sequencer: plays back 3-bit opcodes (line1/line2/obs) from an inferred RAM.
// Define CONC_STIM_LOOP_EN to get continuous looping playback, stopped by a start pulse.
module conc_stim_seq #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ld_we,
  input  logic [AW-1:0] ld_addr,
  input  logic [2:0]    ld_data,
  input  logic [AW:0]   len,
  input  logic          start,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          ld_err,
  output logic          line1,
  output logic          line2,
  output logic          obs,
  output logic [AW:0]   pc
);

`ifdef CONC_STIM_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, FIN} state_t;

  state_t        state_reg, state_next;
  logic [AW:0]   pc_reg, pc_next;
  logic [AW:0]   len_reg, len_next;
  logic          out_valid_reg, out_valid_next;
  logic          done_reg, done_next;
  logic          ld_err_reg, ld_err_next;
  logic          stop_req_reg, stop_req_next;

  logic          is_busy;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data_reg;

  logic [2:0]    store [DEPTH];

  assign is_busy = (state_reg == RUN) || (state_reg == PAUSE);
  assign wr_en   = ld_we && !is_busy;

  // Store has no reset so it maps onto block RAM; the read register is frozen
  // simply by not enabling it, which is how PAUSE holds the outputs.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      store[ld_addr] <= ld_data;
    end
    if (rd_en) begin
      rd_data_reg <= store[rd_addr];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      pc_reg        <= '0;
      len_reg       <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      ld_err_reg    <= 1'b0;
      stop_req_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      len_reg       <= len_next;
      out_valid_reg <= out_valid_next;
      done_reg      <= done_next;
      ld_err_reg    <= ld_err_next;
      stop_req_reg  <= stop_req_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    len_next       = len_reg;
    out_valid_next = out_valid_reg;
    done_next      = 1'b0;
    stop_req_next  = stop_req_reg;
    ld_err_next    = ld_we && is_busy;
    rd_en          = 1'b0;
    rd_addr        = pc_reg[AW-1:0];

    case (state_reg)
      IDLE: begin
        out_valid_next = 1'b0;
        stop_req_next  = 1'b0;
        if (start) begin
          pc_next = '0;
          if (len == '0) begin
            state_next = FIN;
            done_next  = 1'b1;
          end else begin
            state_next = RUN;
            len_next   = len;
          end
        end
      end

      RUN, PAUSE: begin
        if (LOOP_EN && start) begin
          stop_req_next = 1'b1;
        end
        // Hold wins over everything, including the end-of-program edge.
        if (hold) begin
          state_next = PAUSE;
        end else if (pc_reg == len_reg) begin
          done_next = 1'b1;
          if (LOOP_EN && !(stop_req_reg || start)) begin
            state_next = RUN;
            rd_en      = 1'b1;
            rd_addr    = '0;
            pc_next    = (AW+1)'(1);
          end else begin
            state_next     = FIN;
            out_valid_next = 1'b0;
          end
        end else begin
          state_next     = RUN;
          rd_en          = 1'b1;
          pc_next        = pc_reg + 1'b1;
          out_valid_next = 1'b1;
        end
      end

      FIN: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end

      default: begin
        state_next     = IDLE;
        out_valid_next = 1'b0;
      end
    endcase
  end

  // Gating by a reset-able flag forces the lines low asynchronously even
  // though the RAM read register itself is never reset.
  assign line1  = rd_data_reg[0] & out_valid_reg;
  assign line2  = rd_data_reg[1] & out_valid_reg;
  assign obs    = rd_data_reg[2] & out_valid_reg;
  assign busy   = is_busy;
  assign done   = done_reg;
  assign ld_err = ld_err_reg;
  assign pc     = pc_reg;

endmodule
